// File: rtl/ps2_kbd_rx_if.sv
// Decoded-key output bundle of the PS/2 keyboard receiver.
// master: the receiver driving it; slave: the keyboard matrix logic consuming it.
interface ps2_kbd_rx_if;
    logic       KEY_STROBE;
    logic [7:0] KEY_CODE;
    logic       KEY_EXT;
    logic       KEY_REL;
    logic       ERR_STROBE;
    logic       BUSY;

    modport master (
        output KEY_STROBE, KEY_CODE, KEY_EXT, KEY_REL, ERR_STROBE, BUSY
    );

    modport slave (
        input KEY_STROBE, KEY_CODE, KEY_EXT, KEY_REL, ERR_STROBE, BUSY
    );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronize and deglitch the lines, deframe 11-bit frames,
// fold E0/F0 prefixes into flags on a single decoded-key strobe.
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on a clock fall)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking the stop bit, then delivering the byte or flagging an error
module ps2_kbd_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 96000
) (
    input  logic            CLK48M_I,
    input  logic            RESET_I,
    input  logic            PS2_CLK,
    input  logic            PS2_DAT,
    ps2_kbd_rx_if.master    key_if
);
    localparam logic [3:0]  FILT_LAST = 4'(FILTER - 1);
    localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    // Index 0 is the clock line, index 1 the data line.
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       filt_q, filt_d;
    logic [1:0][3:0]  fcnt_q, fcnt_d;
    logic             clk_prev_q;
    logic             fall_q;

    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [16:0]      tmo_q, tmo_d;
    logic             pend_ext_q, pend_ext_d;
    logic             pend_rel_q, pend_rel_d;
    logic [7:0]       key_code_q, key_code_d;
    logic             key_ext_q, key_ext_d;
    logic             key_rel_q, key_rel_d;
    logic             key_stb_q, key_stb_d;
    logic             err_stb_q, err_stb_d;
    logic             dat;

    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FILT_LAST) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK48M_I or posedge RESET_I) begin
        if (RESET_I) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            filt_q     <= 2'b11;
            fcnt_q     <= '0;
            clk_prev_q <= 1'b1;
            fall_q     <= 1'b0;
        end else begin
            sync1_q    <= {PS2_DAT, PS2_CLK};
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            clk_prev_q <= filt_q[0];
            fall_q     <= clk_prev_q & ~filt_q[0];
        end
    end

    assign dat = filt_q[1];

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = '0;
        pend_ext_d = pend_ext_q;
        pend_rel_d = pend_rel_q;
        key_code_d = key_code_q;
        key_ext_d  = key_ext_q;
        key_rel_d  = key_rel_q;
        key_stb_d  = 1'b0;
        err_stb_d  = 1'b0;

        if (state_q != ST_IDLE) begin
            tmo_d = fall_q ? '0 : tmo_q + 17'd1;
        end

        // A stalled frame aborts even if a fall arrives in the same cycle.
        if (state_q != ST_IDLE && tmo_q == TMO_LIMIT) begin
            state_d    = ST_IDLE;
            tmo_d      = '0;
            err_stb_d  = 1'b1;
            pend_ext_d = 1'b0;
            pend_rel_d = 1'b0;
        end else if (fall_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d[bit_cnt_q] = dat;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = dat;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (dat && ^{shift_q, par_q}) begin
                        if (shift_q == 8'hE0) begin
                            pend_ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            pend_rel_d = 1'b1;
                        end else begin
                            key_code_d = shift_q;
                            key_ext_d  = pend_ext_q;
                            key_rel_d  = pend_rel_q;
                            key_stb_d  = 1'b1;
                            pend_ext_d = 1'b0;
                            pend_rel_d = 1'b0;
                        end
                    end else begin
                        err_stb_d  = 1'b1;
                        pend_ext_d = 1'b0;
                        pend_rel_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK48M_I or posedge RESET_I) begin
        if (RESET_I) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            pend_ext_q <= 1'b0;
            pend_rel_q <= 1'b0;
            key_code_q <= '0;
            key_ext_q  <= 1'b0;
            key_rel_q  <= 1'b0;
            key_stb_q  <= 1'b0;
            err_stb_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            pend_ext_q <= pend_ext_d;
            pend_rel_q <= pend_rel_d;
            key_code_q <= key_code_d;
            key_ext_q  <= key_ext_d;
            key_rel_q  <= key_rel_d;
            key_stb_q  <= key_stb_d;
            err_stb_q  <= err_stb_d;
        end
    end

    assign key_if.KEY_STROBE = key_stb_q;
    assign key_if.KEY_CODE   = key_code_q;
    assign key_if.KEY_EXT    = key_ext_q;
    assign key_if.KEY_REL    = key_rel_q;
    assign key_if.ERR_STROBE = err_stb_q;
    assign key_if.BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: hand-built PS/2 frames with hand-computed results.
module tb_ps2_kbd_rx;
    localparam int FILT = 8;
    localparam int TMO  = 1000;
    localparam int HALF = 40;

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk;
    logic ps2_dat;

    ps2_kbd_rx_if key_if ();

    ps2_kbd_rx #(.FILTER(FILT), .TIMEOUT(TMO)) dut (
        .CLK48M_I (clk),
        .RESET_I  (rst),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat),
        .key_if   (key_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int key_cnt = 0;
    int err_cnt = 0;
    int overlap = 0;
    int last_stb_cyc = 0;
    int fall_cyc = 0;
    logic busy_mid;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (key_if.KEY_STROBE) begin
                key_cnt++;
                last_stb_cyc = cyc;
            end
            if (key_if.ERR_STROBE) begin
                err_cnt++;
                last_stb_cyc = cyc;
            end
            if (key_if.KEY_STROBE && key_if.ERR_STROBE) overlap++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // nbits < 11 leaves the frame unfinished with the clock parked high.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_bit,
                              input int nbits, input int glitch_bit);
        logic [10:0] fr;
        fr = {stop_bit, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = fr[i];
            if (i == glitch_bit) begin
                wait_cyc(10);
                ps2_clk = 1'b0;
                wait_cyc(5);
                ps2_clk = 1'b1;
                wait_cyc(HALF - 15);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
            if (i == 5) busy_mid = key_if.BUSY;
        end
        wait_cyc(HALF);
        ps2_dat = 1'b1;
        wait_cyc(100);
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11, -1);
    endtask

    int k0, e0;

    initial begin
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        wait_cyc(3);
        chk("rst_code", key_if.KEY_CODE, 8'h00);
        chk("rst_ext", key_if.KEY_EXT, 1'b0);
        chk("rst_rel", key_if.KEY_REL, 1'b0);
        chk("rst_busy", key_if.BUSY, 1'b0);
        chk("rst_strobes", {key_if.KEY_STROBE, key_if.ERR_STROBE}, 2'b00);
        rst = 1'b0;
        wait_cyc(20);

        // Plain make code
        k0 = key_cnt; e0 = err_cnt;
        good(8'h1C);
        chk("make_strobes", key_cnt - k0, 1);
        chk("make_code", key_if.KEY_CODE, 8'h1C);
        chk("make_flags", {key_if.KEY_EXT, key_if.KEY_REL}, 2'b00);
        chk("make_busy_mid", busy_mid, 1'b1);
        chk("make_busy_end", key_if.BUSY, 1'b0);
        chk("make_no_err", err_cnt - e0, 0);
        chk("make_latency", last_stb_cyc - fall_cyc, FILT + 4);

        // Extended break, then plain make clears the flags
        k0 = key_cnt;
        good(8'hE0);
        good(8'hF0);
        chk("prefix_no_strobe", key_cnt - k0, 0);
        good(8'h75);
        chk("extbrk_strobes", key_cnt - k0, 1);
        chk("extbrk_code", key_if.KEY_CODE, 8'h75);
        chk("extbrk_flags", {key_if.KEY_EXT, key_if.KEY_REL}, 2'b11);
        good(8'h1C);
        chk("after_code", key_if.KEY_CODE, 8'h1C);
        chk("after_flags", {key_if.KEY_EXT, key_if.KEY_REL}, 2'b00);

        // Parity error
        k0 = key_cnt; e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
        chk("par_err", err_cnt - e0, 1);
        chk("par_no_key", key_cnt - k0, 0);
        chk("par_code_held", key_if.KEY_CODE, 8'h1C);
        chk("par_err_latency", last_stb_cyc - fall_cyc, FILT + 4);

        // Release prefix dropped by a stop-bit error
        k0 = key_cnt; e0 = err_cnt;
        good(8'hF0);
        send_frame(8'h33, 1'b0, 1'b0, 11, -1);
        chk("stop_err", err_cnt - e0, 1);
        good(8'h1C);
        chk("drop_rel_key", key_cnt - k0, 1);
        chk("drop_rel_flag", key_if.KEY_REL, 1'b0);

        // Timeout recovery
        e0 = err_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, 5, -1);
        chk("tmo_busy_before", key_if.BUSY, 1'b1);
        wait_cyc(TMO + 200);
        chk("tmo_err", err_cnt - e0, 1);
        chk("tmo_busy", key_if.BUSY, 1'b0);
        good(8'h29);
        chk("tmo_next_code", key_if.KEY_CODE, 8'h29);

        // Glitch immunity on the clock line
        k0 = key_cnt; e0 = err_cnt;
        send_frame(8'h66, 1'b0, 1'b1, 11, 3);
        chk("glitch_strobes", key_cnt - k0, 1);
        chk("glitch_no_err", err_cnt - e0, 0);
        chk("glitch_code", key_if.KEY_CODE, 8'h66);
        chk("glitch_latency", last_stb_cyc - fall_cyc, FILT + 4);

        // Reset mid-frame takes effect without a clock edge
        good(8'hE0);
        send_frame(8'h5A, 1'b0, 1'b1, 6, -1);
        chk("mid_busy", key_if.BUSY, 1'b1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_code", key_if.KEY_CODE, 8'h00);
        chk("midrst_flags", {key_if.KEY_EXT, key_if.KEY_REL}, 2'b00);
        chk("midrst_busy", key_if.BUSY, 1'b0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(20);
        k0 = key_cnt;
        good(8'h5A);
        chk("post_rst_strobes", key_cnt - k0, 1);
        chk("post_rst_code", key_if.KEY_CODE, 8'h5A);
        chk("post_rst_ext", key_if.KEY_EXT, 1'b0);

        chk("strobe_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

PS/2 keyboard receiver for the 48 MHz core domain. It samples the open-collector PS/2 clock and data lines driven by the IO controller's keyboard emulation, and deglitches them. It deframes the 11-bit device-to-host frames and folds the `E0` (extended) and `F0` (release) prefixes into flags on a single decoded-key strobe. The keyboard matrix logic consumes that strobe.

## Interface

Parameters:
- `FILTER`, default 8: consecutive identical synchronized samples required before a filtered line changes; legal range 1–15.
- `TIMEOUT`, default 96000: idle cycles between clock falls that abort a frame in progress (2 ms at 48 MHz); counter is 17 bits.

Ports:
- `CLK48M_I`, in, 1: sole clock, 48 MHz.
- `RESET_I`, in, 1: asynchronous, active-high reset.
- `PS2_CLK`, in, 1: raw PS/2 clock line, asynchronous; idles high.
- `PS2_DAT`, in, 1: raw PS/2 data line, asynchronous; idles high.
- `KEY_STROBE`, out, 1: one-cycle pulse when a complete non-prefix scancode is received.
- `KEY_CODE`, out, 8: scancode; held from strobe to next strobe.
- `KEY_EXT`, out, 1: `E0` preceded `KEY_CODE`; held with `KEY_CODE`.
- `KEY_REL`, out, 1: `F0` preceded `KEY_CODE` (break code); held with `KEY_CODE`.
- `ERR_STROBE`, out, 1: one-cycle pulse on parity error, stop-bit error or timeout.
- `BUSY`, out, 1: high while the frame FSM is not in IDLE.

## Operation

- **Input conditioning**
  - Each line passes a 2-flop synchronizer, then a filter.
  - The filtered value takes the synchronized value once it has been seen for `FILTER` consecutive cycles.
  - Sync flops and filtered values reset to 1.
- **Edge detection and sampling**
  - A fall is the filtered clock going 1→0, registered as a single-cycle `fall` pulse.
  - Filtered data is sampled only on `fall`.
- **Frame FSM**
  - **IDLE**: on `fall` with data 0 (start bit), go to DATA with bit count 0. On `fall` with data 1, stay in IDLE with no error (spurious edge).
  - **DATA**: on each `fall`, shift data into bit `count`, LSB first. After the 8th bit, go to PARITY.
  - **PARITY**: on `fall`, store the parity bit and go to STOP. Parity is odd: the 8 data bits plus the parity bit must contain an odd number of 1s.
  - **STOP**: on `fall`, go to IDLE. If the stop bit is 1 and parity is good, deliver the byte to the prefix logic. Otherwise pulse `ERR_STROBE` and clear both pending prefix flags.
- **Timeout**
  - In any state other than IDLE, the counter increments every cycle and clears on `fall`.
  - Reaching `TIMEOUT` pulses `ERR_STROBE`, returns to IDLE and clears the pending prefix flags.
  - In IDLE the counter is held at 0.
- **Prefix logic** (for a delivered byte b)
  - b=`E0`: set pending_ext; no strobe.
  - b=`F0`: set pending_rel; no strobe.
  - Any other b, including `E1` and `AA`: set `KEY_CODE`=b, `KEY_EXT`=pending_ext, `KEY_REL`=pending_rel. Pulse `KEY_STROBE` and clear both pending flags.
  - Repeated prefixes are idempotent.
- **Reset** (any time, including mid-frame)
  - FSM goes to IDLE; counters and pending flags are cleared.
  - All outputs go to 0: `KEY_CODE`=00, `KEY_EXT`=0, `KEY_REL`=0, `KEY_STROBE`=0, `ERR_STROBE`=0, `BUSY`=0.

## Timing

- Pin-to-`fall` latency is exactly `FILTER`+3 cycles: 2 synchronizer cycles, `FILTER` cycles of stability, 1 edge register.
- `KEY_STROBE` or `ERR_STROBE` asserts the cycle after the `fall` that samples the stop bit. Pin-to-strobe latency is therefore `FILTER`+4 cycles.
- `KEY_CODE`, `KEY_EXT` and `KEY_REL` update in the same cycle that `KEY_STROBE` is high.
- On a timeout, `ERR_STROBE` asserts the cycle after the counter reaches `TIMEOUT`.
- `KEY_STROBE` and `ERR_STROBE` are never high in the same cycle.
- Pulses shorter than `FILTER` cycles on either line produce no `fall` and no state change.
- `BUSY` rises the cycle after the start-bit `fall`. It falls the cycle after the stop-bit `fall`, or at timeout.
- There is no back-pressure: the consumer must accept each `KEY_STROBE`. The minimum spacing between strobes is one PS/2 frame (well above 1000 cycles).

## Test plan

- **Plain make code**: frame `1C` (parity bit 0, stop 1) at 12.5 kHz → one `KEY_STROBE`, `KEY_CODE`=1C, `KEY_EXT`=0, `KEY_REL`=0; `BUSY` is high during the frame.
- **Extended break**: frames `E0`, `F0`, `75` → exactly one `KEY_STROBE`, with `KEY_CODE`=75, `KEY_EXT`=1, `KEY_REL`=1. The next frame `1C` → `KEY_EXT`=0, `KEY_REL`=0.
- **Parity error**: frame `1C` with parity bit 1 → `ERR_STROBE` pulse, no `KEY_STROBE`, `KEY_CODE` unchanged. Sending `F0`, then a bad frame, then `1C` → `KEY_REL`=0.
- **Timeout recovery**: stop the clock after 4 data bits for more than `TIMEOUT` cycles → one `ERR_STROBE` and `BUSY`=0. A following good frame `29` → `KEY_CODE`=29.
- **Glitch immunity**: with `FILTER`=8, inject a 5-cycle low pulse on `PS2_CLK` mid-bit → no extra bit shifted; the frame still decodes correctly. Latency check: pin-to-strobe is exactly 12 cycles.
- **Reset mid-frame**: assert `RESET_I` after 6 bits → all outputs go to 0 and `BUSY`=0 without waiting for a clock edge. After release, a full frame `5A` → `KEY_CODE`=5A.
